phase_tag_accumulator: RTL and testbench

Windowed statistics stage directly downstream of the start/stop phase detector. Consumes the detector's `phase_tag` / `start_count` / `phase_tag_valid` stream and collects 2^LOG2_WINDOW tags into one window. For each window it produces the average, minimum and maximum phase tag, plus a count of missed detector events inferred from gaps in `start_count`. Results leave through a valid/ready port, and a one-deep output register decouples the window accumulation from the consumer.

---
 rtl/phase_tag_accumulator_if.sv | 28 ++
 rtl/phase_tag_accumulator.sv | 106 ++++++++++
 tb/tb_phase_tag_accumulator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/phase_tag_accumulator_if.sv
// Bundles the phase detector tag stream and the windowed-result valid/ready port.
// The master side drives tags and out_ready; the slave side is the accumulator.
interface phase_tag_accumulator_if #(
  parameter int PHASE_COUNT_SIZE = 5,
  parameter int CLK_0_COUNT_SIZE = 3,
  parameter int LOG2_WINDOW      = 4
);
  logic [PHASE_COUNT_SIZE-1:0]            phase_tag;
  logic [CLK_0_COUNT_SIZE-1:0]            start_count;
  logic                                   phase_tag_valid;
  logic [PHASE_COUNT_SIZE-1:0]            avg_out;
  logic [PHASE_COUNT_SIZE-1:0]            min_out;
  logic [PHASE_COUNT_SIZE-1:0]            max_out;
  logic [CLK_0_COUNT_SIZE+LOG2_WINDOW-1:0] miss_out;
  logic                                   out_valid;
  logic                                   out_ready;
  logic                                   overrun;

  modport master (
    output phase_tag, start_count, phase_tag_valid, out_ready,
    input  avg_out, min_out, max_out, miss_out, out_valid, overrun
  );

  modport slave (
    input  phase_tag, start_count, phase_tag_valid, out_ready,
    output avg_out, min_out, max_out, miss_out, out_valid, overrun
  );
endinterface

// File: rtl/phase_tag_accumulator.sv
// Collects 2^LOG2_WINDOW phase tags per window and reports avg/min/max plus
// missed detector events (from start_count gaps) through a one-deep output register.
module phase_tag_accumulator #(
  parameter int PHASE_COUNT_SIZE = 5,
  parameter int CLK_0_COUNT_SIZE = 3,
  parameter int LOG2_WINDOW      = 4
) (
  input logic                    clk_sample,
  input logic                    rst_n,
  phase_tag_accumulator_if.slave bus
);
  localparam int PW = PHASE_COUNT_SIZE;
  localparam int CW = CLK_0_COUNT_SIZE;
  localparam int LW = LOG2_WINDOW;
  localparam int SW = PW + LW;
  localparam int MW = CW + LW;

  typedef enum logic {S_SEED, S_ACCUM} state_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic          run;
  logic [SW-1:0] sum_acc, sum_next;
  logic [PW-1:0] min_acc, max_acc, min_next, max_next;
  logic [MW-1:0] miss_acc, miss_next;
  logic [MW:0]   miss_ext;
  logic [CW-1:0] last_sc, gap, gap_eff;
  logic [LW-1:0] sample_cnt;
  logic [PW-1:0] avg_r, min_r, max_r;
  logic [MW-1:0] miss_r;
  logic          out_valid_r, overrun_r;
  logic          window_done, can_load;

  // Reset asserts immediately but releases the FSM only after two clean edges.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  always_comb begin
    gap         = bus.start_count - last_sc - CW'(1);
    gap_eff     = (state == S_ACCUM) ? gap : '0;
    miss_ext    = {1'b0, miss_acc} + {{(LW+1){1'b0}}, gap_eff};
    miss_next   = miss_ext[MW] ? '1 : miss_ext[MW-1:0];
    sum_next    = sum_acc + {{LW{1'b0}}, bus.phase_tag};
    min_next    = (bus.phase_tag < min_acc) ? bus.phase_tag : min_acc;
    max_next    = (bus.phase_tag > max_acc) ? bus.phase_tag : max_acc;
    window_done = run && bus.phase_tag_valid && (state == S_ACCUM) && (sample_cnt == '1);
    can_load    = !out_valid_r || bus.out_ready;
  end

  // A completed window either replaces the output register or is dropped as an overrun.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_SEED;
      sum_acc     <= '0;
      min_acc     <= '1;
      max_acc     <= '0;
      miss_acc    <= '0;
      last_sc     <= '0;
      sample_cnt  <= '0;
      avg_r       <= '0;
      min_r       <= '0;
      max_r       <= '0;
      miss_r      <= '0;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (run) begin
      if (out_valid_r && bus.out_ready) out_valid_r <= 1'b0;
      if (bus.phase_tag_valid) begin
        state      <= S_ACCUM;
        last_sc    <= bus.start_count;
        sample_cnt <= sample_cnt + LW'(1);
        if (window_done) begin
          sum_acc  <= '0;
          min_acc  <= '1;
          max_acc  <= '0;
          miss_acc <= '0;
          if (can_load) begin
            avg_r       <= sum_next[SW-1:LW];
            min_r       <= min_next;
            max_r       <= max_next;
            miss_r      <= miss_next;
            out_valid_r <= 1'b1;
          end else begin
            overrun_r <= 1'b1;
          end
        end else begin
          sum_acc  <= sum_next;
          min_acc  <= min_next;
          max_acc  <= max_next;
          miss_acc <= miss_next;
        end
      end
    end
  end

  assign bus.avg_out   = avg_r;
  assign bus.min_out   = min_r;
  assign bus.max_out   = max_r;
  assign bus.miss_out  = miss_r;
  assign bus.out_valid = out_valid_r;
  assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_phase_tag_accumulator.sv
// Directed bench for phase_tag_accumulator: a window-level model checked every cycle,
// plus literal expectations at each window boundary.
module tb_phase_tag_accumulator;
  logic clk_sample = 1'b0;
  logic rst_n      = 1'b0;
  int   errors     = 0;
  int   checks     = 0;
  bit   cmp_en     = 1'b0;
  int   sc_run     = 0;

  phase_tag_accumulator_if bus ();
  phase_tag_accumulator dut (.clk_sample(clk_sample), .rst_n(rst_n), .bus(bus));

  always #5 clk_sample = ~clk_sample;

  // Model state: queued tags/gaps of the open window and the expected output register
  int win_tags[$];
  int win_gaps[$];
  int prev_sc;
  bit have_prev;
  int sync_cnt;
  bit exp_valid, exp_overrun;
  int exp_avg, exp_min, exp_max, exp_miss;
  int m_sum, m_min, m_max, m_miss;
  bit m_done;

  task automatic checkField(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    sync_cnt = 0; have_prev = 0; prev_sc = 0;
    exp_valid = 0; exp_overrun = 0;
    exp_avg = 0; exp_min = 0; exp_max = 0; exp_miss = 0;
    forever begin
      @(posedge clk_sample or negedge rst_n);
      if (!rst_n) begin
        win_tags.delete(); win_gaps.delete();
        sync_cnt = 0; have_prev = 0;
        exp_valid = 0; exp_overrun = 0;
        exp_avg = 0; exp_min = 0; exp_max = 0; exp_miss = 0;
      end else begin
        m_done = 0;
        if (sync_cnt == 2 && bus.phase_tag_valid) begin
          win_tags.push_back(int'(bus.phase_tag));
          win_gaps.push_back(have_prev ? ((int'(bus.start_count) - prev_sc - 1) & 7) : 0);
          prev_sc   = int'(bus.start_count);
          have_prev = 1;
          if (win_tags.size() == 16) begin
            m_sum = 0; m_min = 31; m_max = 0; m_miss = 0;
            foreach (win_tags[k]) begin
              m_sum += win_tags[k];
              if (win_tags[k] < m_min) m_min = win_tags[k];
              if (win_tags[k] > m_max) m_max = win_tags[k];
              m_miss += win_gaps[k];
            end
            if (m_miss > 127) m_miss = 127;
            win_tags.delete(); win_gaps.delete();
            m_done = 1;
          end
        end
        if (sync_cnt == 2) begin
          if (m_done) begin
            if (!exp_valid || bus.out_ready) begin
              exp_avg = m_sum / 16; exp_min = m_min; exp_max = m_max; exp_miss = m_miss;
              exp_valid = 1;
            end else begin
              exp_overrun = 1;
            end
          end else if (exp_valid && bus.out_ready) begin
            exp_valid = 0;
          end
        end
        if (sync_cnt < 2) sync_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_sample);
      if (cmp_en) begin
        checkField("model_valid", int'(bus.out_valid), int'(exp_valid));
        checkField("model_overrun", int'(bus.overrun), int'(exp_overrun));
        if (exp_valid) begin
          checkField("model_avg", int'(bus.avg_out), exp_avg);
          checkField("model_min", int'(bus.min_out), exp_min);
          checkField("model_max", int'(bus.max_out), exp_max);
          checkField("model_miss", int'(bus.miss_out), exp_miss);
        end
      end
    end
  end

  task automatic applyStimulus(input bit v, input int tag, input int sc);
    bus.phase_tag_valid = v;
    bus.phase_tag       = 5'(tag);
    bus.start_count     = 3'(sc);
    @(negedge clk_sample);
  endtask

  task automatic sendTag(input int tag);
    applyStimulus(1'b1, tag, sc_run % 8);
    sc_run++;
  endtask

  task automatic checkOutput(input string name, input int avg, input int mn, input int mx,
                             input int miss, input int vld, input int ovr, input bit data);
    checkField({name, "_valid"}, int'(bus.out_valid), vld);
    checkField({name, "_overrun"}, int'(bus.overrun), ovr);
    if (data) begin
      checkField({name, "_avg"}, int'(bus.avg_out), avg);
      checkField({name, "_min"}, int'(bus.min_out), mn);
      checkField({name, "_max"}, int'(bus.max_out), mx);
      checkField({name, "_miss"}, int'(bus.miss_out), miss);
    end
  endtask

  int gap1[16] = '{0, 1, 4, 5, 6, 7, 0, 3, 4, 5, 6, 7, 0, 1, 2, 3};
  int gap2[16] = '{4, 5, 6, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5};

  initial begin
    bus.phase_tag = '0; bus.start_count = '0; bus.phase_tag_valid = 1'b0; bus.out_ready = 1'b1;

    // Reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i[0], i * 5, i);
      if (i == 1) cmp_en = 1'b1;
    end
    checkOutput("reset_hold", 0, 0, 0, 0, 0, 0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 0);
    checkOutput("idle", 0, 0, 0, 0, 0, 0, 1'b0);

    // Constant window, start_count 0..7,0..7
    sc_run = 0;
    for (int i = 0; i < 16; i++) sendTag(7);
    checkOutput("const", 7, 7, 7, 0, 1, 0, 1'b1);
    applyStimulus(1'b0, 0, 0);
    checkOutput("const_pulse", 0, 0, 0, 0, 0, 0, 1'b0);

    // Ramp then all-max window
    for (int i = 0; i < 16; i++) sendTag(i);
    checkOutput("ramp", 7, 0, 15, 0, 1, 0, 1'b1);
    applyStimulus(1'b0, 0, 0);
    for (int i = 0; i < 16; i++) sendTag(31);
    checkOutput("max31", 31, 31, 31, 0, 1, 0, 1'b1);
    applyStimulus(1'b0, 0, 0);

    // Gap detection: 1->4 and 0->3 each add 2, 7->0 adds 0
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, i + 8, gap1[i]);
    checkOutput("gap_a", 15, 8, 23, 4, 1, 0, 1'b1);
    applyStimulus(1'b0, 0, 0);
    // 6->1 jump adds 2
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, i * 2, gap2[i]);
    checkOutput("gap_b", 15, 0, 30, 2, 1, 0, 1'b1);
    applyStimulus(1'b0, 0, 0);
    sc_run = 6;

    // Handshake coinciding with window completion loads the new window
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) sendTag(5);
    checkOutput("hold_a", 5, 5, 5, 0, 1, 0, 1'b1);
    for (int i = 0; i < 15; i++) sendTag(9);
    checkOutput("hold_a_kept", 5, 5, 5, 0, 1, 0, 1'b1);
    bus.out_ready = 1'b1;
    sendTag(9);
    checkOutput("same_cycle", 9, 9, 9, 0, 1, 0, 1'b1);
    applyStimulus(1'b0, 0, 0);
    checkOutput("drain", 0, 0, 0, 0, 0, 0, 1'b0);

    // Backpressure for 32 tags: second window dropped, overrun sticky
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) sendTag(i);
    checkOutput("bp_first", 7, 0, 15, 0, 1, 0, 1'b1);
    for (int i = 16; i < 31; i++) sendTag(i);
    checkOutput("bp_pre_overrun", 7, 0, 15, 0, 1, 0, 1'b1);
    sendTag(31);
    checkOutput("overrun", 7, 0, 15, 0, 1, 1, 1'b1);
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 0, 0);
    checkOutput("overrun_sticky", 0, 0, 0, 0, 0, 1, 1'b0);

    // Mid-window asynchronous reset
    for (int i = 0; i < 5; i++) sendTag(20);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 0, 0, 0, 0, 0, 0, 1'b1);
    #1 rst_n = 1'b1;
    bus.phase_tag_valid = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0);
    sc_run = 5;
    for (int i = 0; i < 16; i++) sendTag(3);
    checkOutput("post_reset", 3, 3, 3, 0, 1, 0, 1'b1);
    applyStimulus(1'b0, 0, 0);
    checkOutput("post_reset_drain", 0, 0, 0, 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
